// File: rtl/cal_pkg.sv
// Shared calendar tables, field widths and conversion helpers for the
// calendar counter and its prescaler.
package cal_pkg;

  localparam int MONTH_W = 4;
  localparam int DAY_W   = 5;
  localparam int DOY_W   = 9;

  localparam logic [DAY_W-1:0] MONTH_DAYS [12] = '{
    5'd31, 5'd28, 5'd31, 5'd30, 5'd31, 5'd30,
    5'd31, 5'd31, 5'd30, 5'd31, 5'd30, 5'd31
  };

  // Days elapsed before the first of each month in a common year.
  localparam logic [DOY_W-1:0] CUM_DAYS [12] = '{
    9'd0,   9'd31,  9'd59,  9'd90,  9'd120, 9'd151,
    9'd181, 9'd212, 9'd243, 9'd273, 9'd304, 9'd334
  };

  function automatic logic [DAY_W-1:0] month_len(input logic [MONTH_W-1:0] month,
                                                  input logic               leap);
    logic [MONTH_W-1:0] idx;
    idx       = month - 4'd1;
    month_len = 5'd31;
    if (month >= 4'd1 && month <= 4'd12) month_len = MONTH_DAYS[idx];
    if (month == 4'd2 && leap) month_len = 5'd29;
  endfunction

  function automatic logic [DOY_W-1:0] ordinal_day(input logic [MONTH_W-1:0] month,
                                                    input logic [DAY_W-1:0]   day,
                                                    input logic               leap);
    logic [MONTH_W-1:0] idx;
    idx         = month - 4'd1;
    ordinal_day = CUM_DAYS[idx] + {4'b0, day};
    if (leap && month >= 4'd3) ordinal_day = ordinal_day + 9'd1;
  endfunction

  function automatic logic [7:0] to_bcd(input logic [DAY_W-1:0] bin);
    logic [DAY_W-1:0] tens;
    logic [DAY_W-1:0] ones;
    tens   = bin / 5'd10;
    ones   = bin - tens * 5'd10;
    to_bcd = {tens[3:0], ones[3:0]};
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: one-cycle tick every CLK_HZ/TICK_HZ enabled cycles,
// frozen while disabled, cleared by clr.
module tick_gen #(
  parameter int CLK_HZ  = 10000000,
  parameter int TICK_HZ = 1
) (
  input  logic ADC_CLK_10,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] TERM = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  assign tick = en && (r_cnt == TERM);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its inputs, independent of block order.
  always_ff @(posedge ADC_CLK_10 or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= (r_cnt == TERM) ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/calendar_counter.sv
// Month/day calendar with up/down advance, validated load, and registered
// BCD plus ordinal-day outputs.
module calendar_counter
  import cal_pkg::*;
#(
  parameter int CLK_HZ  = 10000000,
  parameter int TICK_HZ = 1
) (
  input  logic               ADC_CLK_10,
  input  logic               rst_n,
  input  logic               en,
  input  logic               dir,
  input  logic               leap,
  input  logic               step,
  input  logic               load,
  input  logic [MONTH_W-1:0] load_month,
  input  logic [DAY_W-1:0]   load_day,
  output logic [7:0]         month_bcd,
  output logic [7:0]         day_bcd,
  output logic [DOY_W-1:0]   day_of_year,
  output logic               wrap,
  output logic               load_err
);

  logic               w_tick;
  logic [MONTH_W-1:0] w_prev_month;
  logic [DAY_W-1:0]   w_cur_len;
  logic [DAY_W-1:0]   w_prev_len;
  logic [DAY_W-1:0]   w_load_len;
  logic [MONTH_W-1:0] w_next_month;
  logic [DAY_W-1:0]   w_next_day;
  logic               w_wrap;
  logic               w_load_err;

  logic [MONTH_W-1:0] r_month;
  logic [DAY_W-1:0]   r_day;
  logic [7:0]         r_month_bcd;
  logic [7:0]         r_day_bcd;
  logic [DOY_W-1:0]   r_doy;
  logic               r_wrap;
  logic               r_load_err;

  tick_gen #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ)
  ) u_tick_gen (
    .ADC_CLK_10 (ADC_CLK_10),
    .rst_n      (rst_n),
    .en         (en),
    .clr        (load),
    .tick       (w_tick)
  );

  assign w_prev_month = (r_month == 4'd1) ? 4'd12 : r_month - 4'd1;
  assign w_cur_len    = month_len(r_month, leap);
  assign w_prev_len   = month_len(w_prev_month, leap);
  assign w_load_len   = month_len(load_month, leap);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_month = r_month;
    w_next_day   = r_day;
    w_wrap       = 1'b0;
    w_load_err   = 1'b0;
    if (load) begin
      if (load_month == 4'd0 || load_month > 4'd12) begin
        w_load_err = 1'b1;
      end else begin
        w_next_month = load_month;
        if (load_day == 5'd0) begin
          w_next_day = 5'd1;
          w_load_err = 1'b1;
        end else if (load_day > w_load_len) begin
          w_next_day = w_load_len;
          w_load_err = 1'b1;
        end else begin
          w_next_day = load_day;
        end
      end
    end else if (w_tick || step) begin
      if (!dir) begin
        // A stranded Feb 29 (leap dropped) falls through to Mar 1 here.
        if (r_day < w_cur_len) begin
          w_next_day = r_day + 5'd1;
        end else begin
          w_next_day   = 5'd1;
          w_wrap       = (r_month == 4'd12);
          w_next_month = w_wrap ? 4'd1 : r_month + 4'd1;
        end
      end else begin
        if (r_day > 5'd1) begin
          w_next_day = r_day - 5'd1;
        end else begin
          w_next_month = w_prev_month;
          w_next_day   = w_prev_len;
          w_wrap       = (r_month == 4'd1);
        end
      end
    end
  end

  // Ordinal day is recomputed every cycle so a leap change shows up even
  // without an advance.
  always_ff @(posedge ADC_CLK_10 or negedge rst_n) begin
    if (!rst_n) begin
      r_month     <= 4'd1;
      r_day       <= 5'd1;
      r_month_bcd <= 8'h01;
      r_day_bcd   <= 8'h01;
      r_doy       <= 9'd1;
      r_wrap      <= 1'b0;
      r_load_err  <= 1'b0;
    end else begin
      r_month     <= w_next_month;
      r_day       <= w_next_day;
      r_month_bcd <= to_bcd({1'b0, w_next_month});
      r_day_bcd   <= to_bcd(w_next_day);
      r_doy       <= ordinal_day(w_next_month, w_next_day, leap);
      r_wrap      <= w_wrap;
      r_load_err  <= w_load_err;
    end
  end

  assign month_bcd   = r_month_bcd;
  assign day_bcd     = r_day_bcd;
  assign day_of_year = r_doy;
  assign wrap        = r_wrap;
  assign load_err    = r_load_err;

endmodule

// File: tb/tb_calendar_counter.sv
// Directed bench for calendar_counter with a 10-cycle prescaler period.
module tb_calendar_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       dir;
  logic       leap;
  logic       step;
  logic       load;
  logic [3:0] load_month;
  logic [4:0] load_day;
  logic [7:0] month_bcd;
  logic [7:0] day_bcd;
  logic [8:0] day_of_year;
  logic       wrap;
  logic       load_err;

  int n_tests = 0;
  int n_fail  = 0;

  calendar_counter #(
    .CLK_HZ  (10),
    .TICK_HZ (1)
  ) dut (
    .ADC_CLK_10  (clk),
    .rst_n       (rst_n),
    .en          (en),
    .dir         (dir),
    .leap        (leap),
    .step        (step),
    .load        (load),
    .load_month  (load_month),
    .load_day    (load_day),
    .month_bcd   (month_bcd),
    .day_bcd     (day_bcd),
    .day_of_year (day_of_year),
    .wrap        (wrap),
    .load_err    (load_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_date(input string tag, input logic [7:0] m, input logic [7:0] d,
                            input logic [8:0] doy);
    check({tag, ".month"}, {24'h0, month_bcd}, {24'h0, m});
    check({tag, ".day"},   {24'h0, day_bcd},   {24'h0, d});
    check({tag, ".doy"},   {23'h0, day_of_year}, {23'h0, doy});
  endtask

  task automatic check_flags(input string tag, input logic w, input logic e);
    check({tag, ".wrap"},     {31'h0, wrap},     {31'h0, w});
    check({tag, ".load_err"}, {31'h0, load_err}, {31'h0, e});
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [3:0] m, input logic [4:0] d);
    @(negedge clk);
    load       = 1'b1;
    load_month = m;
    load_day   = d;
    cycle();
    load = 1'b0;
  endtask

  task automatic do_step();
    @(negedge clk);
    step = 1'b1;
    cycle();
    step = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; dir = 1'b0; leap = 1'b0; step = 1'b0;
    load = 1'b0; load_month = 4'd0; load_day = 5'd0;

    repeat (3) cycle();
    check_date("reset", 8'h01, 8'h01, 9'd1);
    check_flags("reset", 1'b0, 1'b0);

    // Three prescaler ticks from release.
    en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      cycle();
      if (k == 9)  check("pre.k9",  {24'h0, day_bcd}, 32'h01);
      if (k == 10) check("pre.k10", {24'h0, day_bcd}, 32'h02);
      if (k == 20) check("pre.k20", {24'h0, day_bcd}, 32'h03);
      if (k == 30) check_date("pre.k30", 8'h01, 8'h04, 9'd4);
    end
    check_flags("pre.end", 1'b0, 1'b0);
    @(negedge clk);
    en = 1'b0;

    // Year roll-over both ways.
    do_load(4'd12, 5'd31);
    check_date("ld1231", 8'h12, 8'h31, 9'd365);
    check_flags("ld1231", 1'b0, 1'b0);
    do_step();
    check_date("up_wrap", 8'h01, 8'h01, 9'd1);
    check_flags("up_wrap", 1'b1, 1'b0);
    cycle();
    check_flags("up_wrap.after", 1'b0, 1'b0);
    dir = 1'b1;
    do_step();
    check_date("dn_wrap", 8'h12, 8'h31, 9'd365);
    check_flags("dn_wrap", 1'b1, 1'b0);
    cycle();
    check_flags("dn_wrap.after", 1'b0, 1'b0);
    dir = 1'b0;

    // Leap February.
    leap = 1'b1;
    do_load(4'd2, 5'd28);
    check_date("ld0228", 8'h02, 8'h28, 9'd59);
    do_step();
    check_date("leap.0229", 8'h02, 8'h29, 9'd60);
    check_flags("leap.0229", 1'b0, 1'b0);
    do_step();
    check_date("leap.0301", 8'h03, 8'h01, 9'd61);
    @(negedge clk);
    leap = 1'b0;
    cycle();
    check_date("noleap.0301", 8'h03, 8'h01, 9'd60);

    // Leap dropping while parked on Feb 29.
    leap = 1'b1;
    do_load(4'd2, 5'd29);
    check_date("ld0229", 8'h02, 8'h29, 9'd60);
    check_flags("ld0229", 1'b0, 1'b0);
    @(negedge clk);
    leap = 1'b0;
    cycle();
    cycle();
    check_date("hold0229", 8'h02, 8'h29, 9'd60);
    do_step();
    check_date("strand.up", 8'h03, 8'h01, 9'd60);
    leap = 1'b1;
    do_load(4'd2, 5'd29);
    @(negedge clk);
    leap = 1'b0;
    dir  = 1'b1;
    do_step();
    check_date("strand.dn", 8'h02, 8'h28, 9'd59);
    dir = 1'b0;
    do_load(4'd2, 5'd29);
    check_date("clamp0229", 8'h02, 8'h28, 9'd59);
    check_flags("clamp0229", 1'b0, 1'b1);

    // Month-boundary down-steps.
    leap = 1'b1;
    do_load(4'd3, 5'd1);
    dir = 1'b1;
    do_step();
    check_date("dn.0301", 8'h02, 8'h29, 9'd60);
    leap = 1'b0;
    do_load(4'd5, 5'd1);
    do_step();
    check_date("dn.0501", 8'h04, 8'h30, 9'd120);
    check_flags("dn.0501", 1'b0, 1'b0);
    dir = 1'b0;

    // Load validation.
    do_load(4'd4, 5'd31);
    check_date("ld0431", 8'h04, 8'h30, 9'd120);
    check_flags("ld0431", 1'b0, 1'b1);
    cycle();
    check_flags("ld0431.after", 1'b0, 1'b0);
    do_load(4'd13, 5'd5);
    check_date("ld1305", 8'h04, 8'h30, 9'd120);
    check_flags("ld1305", 1'b0, 1'b1);
    do_load(4'd0, 5'd7);
    check_date("ld0007", 8'h04, 8'h30, 9'd120);
    check_flags("ld0007", 1'b0, 1'b1);
    do_load(4'd5, 5'd0);
    check_date("ld0500", 8'h05, 8'h01, 9'd121);
    check_flags("ld0500", 1'b0, 1'b1);
    do_load(4'd11, 5'd19);
    check_date("ld1119", 8'h11, 8'h19, 9'd323);
    check_flags("ld1119", 1'b0, 1'b0);

    // Load clears the prescaler; tick coinciding with step advances once.
    @(negedge clk);
    en = 1'b1;
    repeat (5) cycle();
    do_load(4'd6, 5'd15);
    for (int k = 1; k <= 9; k++) cycle();
    check_date("clr.k9", 8'h06, 8'h15, 9'd166);
    do_step();
    check_date("tick_step", 8'h06, 8'h16, 9'd167);
    @(negedge clk);
    en = 1'b0;

    // Load beats a coincident step.
    @(negedge clk);
    load = 1'b1; load_month = 4'd7; load_day = 5'd4; step = 1'b1;
    cycle();
    load = 1'b0; step = 1'b0;
    check_date("ld_step", 8'h07, 8'h04, 9'd185);
    check_flags("ld_step", 1'b0, 1'b0);

    // Asynchronous reset in the middle of a prescaler period.
    @(negedge clk);
    en = 1'b1;
    repeat (4) cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check_date("async_rst", 8'h01, 8'h01, 9'd1);
    check_flags("async_rst", 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cycle();
      if (k == 9)  check("rst.k9",  {24'h0, day_bcd}, 32'h01);
      if (k == 10) check("rst.k10", {24'h0, day_bcd}, 32'h02);
    end
    en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/calendar_counter.md
CALENDAR_COUNTER -- requirements
Module: calendar_counter

Interface
REQ-001 SHALL have parameter CLK_HZ, default 10000000, input clock frequency in Hz.
REQ-002 SHALL have parameter TICK_HZ, default 1, automatic advance rate in Hz; CLK_HZ/TICK_HZ SHALL be an integer >= 2.
REQ-003 ADC_CLK_10  input  1  sole clock, rising-edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  enables automatic advance from the prescaler.
REQ-006 dir  input  1  0 = count up (next date), 1 = count down (previous date).
REQ-007 leap  input  1  February has 29 days when 1.
REQ-008 step  input  1  single-cycle manual advance strobe, honoured regardless of en.
REQ-009 load  input  1  single-cycle date load strobe.
REQ-010 load_month  input  4  binary month for load, legal 1..12.
REQ-011 load_day  input  5  binary day for load, legal 1..31.
REQ-012 month_bcd  output  8  current month, [7:4] tens, [3:0] ones.
REQ-013 day_bcd  output  8  current day, [7:4] tens, [3:0] ones.
REQ-014 day_of_year  output  9  binary ordinal day, 1..365, or 1..366 when leap.
REQ-015 wrap  output  1  one-cycle pulse on year roll-over in either direction.
REQ-016 load_err  output  1  one-cycle pulse when a load was rejected or clamped.

Function
REQ-017 Prescaler SHALL count 0..CLK_HZ/TICK_HZ-1 while en=1, raise tick for one cycle at terminal count, then restart at 0.
REQ-018 Prescaler SHALL hold its value while en=0 and clear to 0 on any load.
REQ-019 Advance event = tick OR step; coincident tick and step SHALL produce one advance.
REQ-020 All outputs SHALL be registered and update on the same rising edge that samples an advance or load (latency 1 cycle).
REQ-021 Up: day < month length -> day+1; otherwise day=1 and month+1; Dec 31 -> Jan 1 with wrap=1.
REQ-022 Down: day > 1 -> day-1; otherwise month-1 and day = that month's length; Jan 1 -> Dec 31 with wrap=1.
REQ-023 Month lengths: 31,28/29,31,30,31,30,31,31,30,31,30,31; February uses leap sampled on the advancing cycle.
REQ-024 Leap falling while on Feb 29: date SHALL hold; next up-advance -> Mar 1, next down-advance -> Feb 28.
REQ-025 load SHALL take priority over a coincident advance; the advance is discarded.
REQ-026 Load with month 0 or >12: date unchanged, prescaler still cleared, load_err=1.
REQ-027 Load with legal month and day 0: day=1, load_err=1; day > month length: day = month length, load_err=1; otherwise exact load, load_err=0.
REQ-028 day_of_year SHALL equal cumulative days of preceding months plus day, +1 for month >= 3 when leap=1; it SHALL track leap combinationally-registered every cycle, not only on advance.
REQ-029 BCD outputs SHALL be exact decimal encodings of the binary month/day; codes A-F never appear.
REQ-030 wrap and load_err SHALL be 0 on every cycle not named above.

Reset
REQ-031 rst_n low SHALL immediately force month=1, day=1: month_bcd=8'h01, day_bcd=8'h01, day_of_year=1, wrap=0, load_err=0, prescaler=0.
REQ-032 Reset asserted mid-count or mid-load SHALL discard the pending operation; first advance after release occurs a full prescaler period after en is seen high.

Structure
REQ-033 Package cal_pkg SHALL hold the month-length table, cumulative-days table, month/day width constants and the binary-to-BCD function.
REQ-034 Prescaler SHALL be a separate sub-module tick_gen (parameters CLK_HZ, TICK_HZ; ports ADC_CLK_10, rst_n, en, clr, tick).
REQ-035 Date state SHALL be held in binary; BCD and day_of_year derived from it.

Verification (bench uses CLK_HZ=10, TICK_HZ=1)
REQ-036 Reset release, en=1, dir=0, 30 cycles -> three ticks, day_bcd 01->02->03->04 on cycles 10, 20, 30; day_of_year=4.
REQ-037 load 12/31, one step, dir=0 -> month_bcd=8'h01, day_bcd=8'h01, day_of_year=1, wrap pulse one cycle; repeat with dir=1 from 01/01 -> 12/31, day_of_year=365.
REQ-038 leap=1, load 02/28, step up twice -> 02/29 (doy 60) then 03/01 (doy 61); leap=0 at 03/01 -> doy 60 next cycle.
REQ-039 load 04/31 -> day_bcd=8'h30, load_err pulse; load 13/05 -> date unchanged, load_err pulse; load 00/xx -> unchanged, load_err.
REQ-040 load and step in same cycle with load 07/04 -> 07/04, no advance; assert rst_n low mid-prescale -> outputs 01/01 asynchronously, no wrap.
